// File: rtl/tawas_regfile_mt.sv
// tawas_regfile_mt: per-slice register banks with RCN pending scoreboard and write-collision flag
// Optional TAWAS_REGFILE_RCN_BYPASS_EN forwards a winning RCN return to same-cycle reads.
module tawas_regfile_mt #(
  parameter int THREADS = 4,
  parameter int REGS = 16,
  parameter int DW = 32,
  parameter int LINK_REG = 7,
  parameter int PTR_BASE = 8,
  localparam int TW = $clog2(THREADS),
  localparam int RW = $clog2(REGS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [TW-1:0]               SLICE,
  input  logic                        PC_STORE,
  input  logic [23:0]                 PC,
  input  logic [7:0]                  AU_FLAGS,
  input  logic                        RF_IMM_VLD,
  input  logic [RW-1:0]               RF_IMM_SEL,
  input  logic [DW-1:0]               RF_IMM,
  input  logic                        AU_RC_VLD,
  input  logic [RW-1:0]               AU_RC_SEL,
  input  logic [DW-1:0]               AU_RC,
  input  logic                        LS_PTR_UPD_VLD,
  input  logic [2:0]                  LS_PTR_UPD_SEL,
  input  logic [DW-1:0]               LS_PTR_UPD,
  input  logic                        LS_LOAD_VLD,
  input  logic [RW-1:0]               LS_LOAD_SEL,
  input  logic [DW-1:0]               LS_LOAD,
  input  logic                        RCN_REQ_VLD,
  input  logic [TW-1:0]               RCN_REQ_SLICE,
  input  logic [RW-1:0]               RCN_REQ_SEL,
  input  logic                        RCN_LOAD_VLD,
  input  logic [TW-1:0]               RCN_LOAD_SLICE,
  input  logic [RW-1:0]               RCN_LOAD_SEL,
  input  logic [DW-1:0]               RCN_LOAD,
  input  logic [RW-1:0]               AU_RA_SEL,
  input  logic [RW-1:0]               AU_RB_SEL,
  input  logic [RW-1:0]               LS_STORE_SEL,
  input  logic [2:0]                  LS_PTR_SEL,
  output logic [DW-1:0]               AU_RA,
  output logic [DW-1:0]               AU_RB,
  output logic [DW-1:0]               LS_PTR,
  output logic [DW-1:0]               LS_STORE,
  output logic [23:0]                 PC_RTN,
  output logic [7:0]                  AU_FLAGS_RTN,
  output logic                        RD_STALL,
  output logic [THREADS-1:0]          PEND_ANY,
  output logic                        WR_COLLIDE
);
  localparam logic [RW-1:0] LINK = RW'(LINK_REG);
`ifdef TAWAS_REGFILE_RCN_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [THREADS-1:0][REGS-1:0][DW-1:0] rf;
  logic [THREADS-1:0][REGS-1:0] pend;
  logic [TW-1:0] sm1;
  logic [TW-1:0] wsl [6];
  logic [RW-1:0] wrg [6];
  logic [DW-1:0] wdt [6];
  logic [5:0] wv;
  logic collide, rcn_wins;
  logic [RW-1:0] rsel [4];
  logic [DW-1:0] rdat [4];
  logic [3:0] fwd;
  assign sm1 = SLICE - TW'(1);
  // Port index order is write priority, 0 highest; RCN_LOAD is last
  always_comb begin
    wv = {RCN_LOAD_VLD, PC_STORE, RF_IMM_VLD, AU_RC_VLD, LS_PTR_UPD_VLD, LS_LOAD_VLD};
    wsl[0] = SLICE;
    wrg[0] = LS_LOAD_SEL;
    wdt[0] = LS_LOAD;
    wsl[1] = SLICE + TW'(2);
    wrg[1] = RW'(PTR_BASE) + RW'(LS_PTR_UPD_SEL);
    wdt[1] = LS_PTR_UPD;
    wsl[2] = SLICE + TW'(1);
    wrg[2] = AU_RC_SEL;
    wdt[2] = AU_RC;
    wsl[3] = sm1;
    wrg[3] = RF_IMM_SEL;
    wdt[3] = RF_IMM;
    wsl[4] = sm1;
    wrg[4] = LINK;
    wdt[4] = DW'({AU_FLAGS, PC});
    wsl[5] = RCN_LOAD_SLICE;
    wrg[5] = RCN_LOAD_SEL;
    wdt[5] = RCN_LOAD;
    collide = 1'b0;
    rcn_wins = wv[5];
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++)
        if (wv[i] && wv[j] && wsl[i] == wsl[j] && wrg[i] == wrg[j]) begin
          collide = 1'b1;
          if (j == 5) rcn_wins = 1'b0;
        end
  end
  always_comb begin
    rsel[0] = AU_RA_SEL;
    rsel[1] = AU_RB_SEL;
    rsel[2] = LS_STORE_SEL;
    rsel[3] = RW'(PTR_BASE) + RW'(LS_PTR_SEL);
    RD_STALL = 1'b0;
    fwd = '0;
    for (int i = 0; i < 4; i++) begin
      fwd[i] = BYPASS && rcn_wins && RCN_LOAD_SLICE == sm1 && RCN_LOAD_SEL == rsel[i];
      rdat[i] = fwd[i] ? RCN_LOAD : rf[sm1][rsel[i]];
      RD_STALL = RD_STALL | (pend[sm1][rsel[i]] & ~fwd[i]);
    end
  end
  always_comb
    for (int t = 0; t < THREADS; t++) PEND_ANY[t] = |pend[t];
  assign AU_RA = rdat[0];
  assign AU_RB = rdat[1];
  assign LS_STORE = rdat[2];
  assign LS_PTR = rdat[3];
  assign PC_RTN = rf[sm1][LINK][23:0];
  assign AU_FLAGS_RTN = rf[sm1][LINK][31:24];
  // Lowest priority first so the highest-priority NBA lands last
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rf <= '0;
      pend <= '0;
      WR_COLLIDE <= 1'b0;
    end else begin
      for (int i = 5; i >= 0; i--)
        if (wv[i]) rf[wsl[i]][wrg[i]] <= wdt[i];
      if (RCN_LOAD_VLD) pend[RCN_LOAD_SLICE][RCN_LOAD_SEL] <= 1'b0;
      if (RCN_REQ_VLD) pend[RCN_REQ_SLICE][RCN_REQ_SEL] <= 1'b1;
      WR_COLLIDE <= collide;
    end
endmodule

// File: doc/tawas_regfile_mt.md
# tawas_regfile_mt

Parametrised multi-thread register file for the Tawas barrel-threaded core. It holds one register bank per hardware thread (slice) and maps each pipeline stage's read or write port onto the correct bank by fixed slice offsets. It adds a per-register scoreboard of outstanding RCN (remote) loads, with a read-stall indication, and reports same-cycle write collisions. It sits between decode/AU/LS stages and the RCN bus interface, replacing the fixed 4x16x32 file.

## Interface
- THREADS, 4, number of slices; power of 2, >=4.
- REGS, 16, registers per slice; power of 2, >=8.
- DW, 32, register width; >=32.
- LINK_REG, 7, register receiving {AU_FLAGS, PC} on PC_STORE.
- PTR_BASE, 8, pointer-register base; pointer index = PTR_BASE + 3-bit select.
- Widths: TW = log2(THREADS), RW = log2(REGS).
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- SLICE  in  TW  current issue slice.
- PC_STORE, PC[23:0], AU_FLAGS[7:0]  in  link write, slice SLICE-1.
- RF_IMM_VLD, RF_IMM_SEL[RW], RF_IMM[DW]  in  immediate write, slice SLICE-1.
- AU_RC_VLD, AU_RC_SEL[RW], AU_RC[DW]  in  AU result write, slice SLICE+1.
- LS_PTR_UPD_VLD, LS_PTR_UPD_SEL[3], LS_PTR_UPD[DW]  in  pointer writeback, slice SLICE+2.
- LS_LOAD_VLD, LS_LOAD_SEL[RW], LS_LOAD[DW]  in  local load write, slice SLICE.
- RCN_REQ_VLD, RCN_REQ_SLICE[TW], RCN_REQ_SEL[RW]  in  remote load issued; marks register pending.
- RCN_LOAD_VLD, RCN_LOAD_SLICE[TW], RCN_LOAD_SEL[RW], RCN_LOAD[DW]  in  remote load return; writes and clears pending.
- AU_RA_SEL, AU_RB_SEL, LS_STORE_SEL [RW]; LS_PTR_SEL [3]  in  read selects, slice SLICE-1.
- AU_RA, AU_RB, LS_PTR, LS_STORE  out  DW  read data.
- PC_RTN  out  24  LINK_REG[23:0] of slice SLICE-1; AU_FLAGS_RTN  out  8  LINK_REG[31:24].
- RD_STALL  out  1  any of RA/RB/STORE/PTR selects a pending register in slice SLICE-1.
- PEND_ANY  out  THREADS  per-slice OR of pending bits.
- WR_COLLIDE  out  1  registered pulse: two or more writes hit the same slice/register last cycle.

## Operation
- All slice arithmetic is modulo THREADS.
- Storage: THREADS x REGS x DW flops, plus a THREADS x REGS pending array.
- Write priority on the same slice/register, highest first: LS_LOAD, LS_PTR_UPD, AU_RC, RF_IMM, PC_STORE, RCN_LOAD. Only the winner is written.
- PC_STORE writes {zeros, AU_FLAGS, PC}: AU_FLAGS in [31:24], PC in [23:0], bits above 31 zero.
- Pending bit update:
  - Set by RCN_REQ_VLD.
  - Cleared by RCN_LOAD_VLD, including when the RCN data loses priority.
  - If both target the same bit in one cycle, set wins.
  - Local writes never clear a pending bit.
- RD_STALL and PEND_ANY are combinational from the pending array and the selects.
- Data outputs are combinational reads of the current array; read-after-write within one cycle returns old data (unless the Configuration option below is enabled).
- WR_COLLIDE counts every valid port (all six) for collision purposes.

## Timing
- Write latency: 1 cycle; data is visible on reads in the cycle after the write edge.
- Pending bit visible on RD_STALL in the cycle after RCN_REQ_VLD; cleared in the cycle after RCN_LOAD_VLD.
- WR_COLLIDE asserts exactly one cycle after the colliding cycle, for one cycle.
- Reset (asynchronous, any time, including with a load outstanding):
  - All registers 0, all pending bits 0, WR_COLLIDE 0.
  - Hence AU_RA/AU_RB/LS_PTR/LS_STORE = 0, PC_RTN = 0, AU_FLAGS_RTN = 0, RD_STALL = 0, PEND_ANY = 0.
  - An RCN return arriving after reset writes data normally; clearing an already-clear pending bit is harmless.

## Configuration
- TAWAS_REGFILE_RCN_BYPASS_EN defined: an RCN_LOAD_VLD targeting slice SLICE-1 is forwarded combinationally to any read port selecting that register, and suppresses RD_STALL for that register in that cycle. Forwarding applies only when RCN_LOAD wins priority for the register.
- Not defined: no forwarding; reads see the returned value one cycle later, and RD_STALL stays high until the cycle after the return.

## Test plan
- Reset, then SLICE=1, AU_RA_SEL=3 -> AU_RA=0, PC_RTN=0, RD_STALL=0.
- SLICE=0, AU_RC_VLD sel 5 data 0xDEADBEEF -> after one cycle, SLICE=2 read RA sel 5 returns 0xDEADBEEF (bank 1).
- SLICE=1, RF_IMM_VLD sel 7 = 0x11 together with PC_STORE PC=0x123456 flags=0xA5 -> bank 0 r7 = 0x00000011; WR_COLLIDE pulses the next cycle.
- RCN_REQ slice 3 reg 2, then SLICE=0 RA_SEL=2 -> RD_STALL=1, PEND_ANY=4'b1000. RCN_LOAD 0xCAFE -> RD_STALL=0 next cycle (same cycle if bypass is enabled), RA=0xCAFE.
- RCN_REQ and RCN_LOAD to the same bit in one cycle -> pending stays set, data written.
- Assert RST mid-operation with a load pending -> all outputs 0 immediately; a later RCN_LOAD writes data, PEND_ANY stays 0.
